// File: rtl/kb_hit_conditioner_pkg.sv
// Shared definitions for the keyboard hit path. mainDataPath and the VGA
// helper use the same mole index width and FSM state encodings.
package kb_hit_conditioner_pkg;

  localparam int MOLE_IDX_W    = 3;
  localparam int NUM_MOLES_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_HELD    = 2'd2,
    ST_LOCKOUT = 2'd3
  } kb_state_e;

  // One staged hit on its way into the buffer.
  typedef struct packed {
    logic                  vld;
    logic [MOLE_IDX_W-1:0] idx;
  } hit_req_t;

endpackage

// File: rtl/kb_hit_conditioner_fifo.sv
// Synchronous first-word fall-through FIFO for accepted mole hits.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// dout holds the last head value shown once the FIFO drains.
module hit_fifo
  import kb_hit_conditioner_pkg::*;
#(
  parameter int WIDTH = MOLE_IDX_W,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] hold_q;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? hold_q : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are only observed while occupied, so no reset.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Track the current head so dout keeps its last value once empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       hold_q <= '0;
    else if (!empty) hold_q <= mem[rd_ptr];
  end

endmodule

// File: rtl/kb_hit_conditioner.sv
// Turns the keyboard decoder's level key_pressed/data pair into one mole-hit
// token per press: edge detect, range check, held/repeat suppression and a
// post-release lockout, with a small FWFT buffer on a valid/ready output.
// Hits are staged one register before the buffer, giving a rise-to-valid
// latency of two clocks.
module kb_hit_conditioner
  import kb_hit_conditioner_pkg::*;
#(
  parameter int NUM_MOLES      = NUM_MOLES_DEF,
  parameter int LOCKOUT_CYCLES = 500000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            kb_data,
  input  logic                  kb_key_pressed,
  input  logic                  game_active,
  output logic                  hit_valid,
  output logic [MOLE_IDX_W-1:0] hit_index,
  input  logic                  hit_ready,
  output logic                  overflow,
  output logic [7:0]            invalid_count
);

  localparam int         CNT_W       = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [4:0] NUM_MOLES_L = 5'(NUM_MOLES);

  kb_state_e        state_q, state_d;
  logic             kp_q, rise;
  logic [3:0]       code_q;
  logic [CNT_W-1:0] lock_cnt_q;
  hit_req_t         push_q;
  logic             latch_code, chk_valid, chk_invalid, load_cnt;
  logic             fifo_empty, fifo_full, pop;

  assign rise      = kb_key_pressed & ~kp_q;
  assign hit_valid = ~fifo_empty;
  assign pop       = hit_valid & hit_ready;

  // Next-state and per-state strobes; game_active low overrides everything.
  always_comb begin
    state_d     = state_q;
    latch_code  = 1'b0;
    chk_valid   = 1'b0;
    chk_invalid = 1'b0;
    load_cnt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          latch_code = 1'b1;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ({1'b0, code_q} < NUM_MOLES_L) chk_valid   = 1'b1;
        else                              chk_invalid = 1'b1;
        state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!kb_key_pressed) begin
          load_cnt = 1'b1;
          state_d  = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!game_active) begin
      state_d     = ST_IDLE;
      latch_code  = 1'b0;
      chk_valid   = 1'b0;
      chk_invalid = 1'b0;
      load_cnt    = 1'b0;
    end
  end

  // FSM state, edge-detect history and latched key code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kp_q    <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      kp_q    <= kb_key_pressed;
      if (latch_code) code_q <= kb_data;
    end
  end

  // Lockout counter: loaded on release, counts down to zero, cleared by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                        lock_cnt_q <= '0;
    else if (!game_active)                            lock_cnt_q <= '0;
    else if (load_cnt)                                lock_cnt_q <= CNT_W'(LOCKOUT_CYCLES - 1);
    else if (state_q == ST_LOCKOUT && lock_cnt_q != '0) lock_cnt_q <= lock_cnt_q - 1'b1;
  end

  // Staging register between the range check and the buffer write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      push_q <= '0;
    end else begin
      push_q.vld <= chk_valid;
      push_q.idx <= code_q[MOLE_IDX_W-1:0];
    end
  end

  // Sticky overflow and saturating invalid-press statistics; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow      <= 1'b0;
      invalid_count <= '0;
    end else begin
      if (game_active && push_q.vld && fifo_full && !pop) overflow <= 1'b1;
      if (chk_invalid && invalid_count != 8'hFF) invalid_count <= invalid_count + 8'd1;
    end
  end

  hit_fifo #(
    .WIDTH (MOLE_IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (~game_active),
    .push  (push_q.vld),
    .din   (push_q.idx),
    .pop   (pop),
    .dout  (hit_index),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_kb_hit_conditioner.sv
// Bench for kb_hit_conditioner: directed presses, a press-level reference
// model compared every cycle, and hand-computed literal expectations.
module tb_kb_hit_conditioner;

  localparam int NM = 5;
  localparam int L  = 8;
  localparam int D  = 4;

  logic       clock, reset;
  logic [3:0] kb_data;
  logic       kb_key_pressed, game_active, hit_ready;
  logic       hit_valid, overflow;
  logic [2:0] hit_index;
  logic [7:0] invalid_count;

  int checks = 0;
  int errors = 0;

  kb_hit_conditioner #(.NUM_MOLES(NM), .LOCKOUT_CYCLES(L), .FIFO_DEPTH(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .kb_data        (kb_data),
    .kb_key_pressed (kb_key_pressed),
    .game_active    (game_active),
    .hit_valid      (hit_valid),
    .hit_index      (hit_index),
    .hit_ready      (hit_ready),
    .overflow       (overflow),
    .invalid_count  (invalid_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (press/time level) ----------------
  int  q[$];
  int  m_last, m_inv, cyc, rel_from, lock_end;
  bit  m_ov, m_busy, m_prev, m_rise;
  bit  chk_pend, push_pend;
  int  chk_t, chk_code, push_t, push_code;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_last = 0; m_inv = 0; m_ov = 0; m_busy = 0; m_prev = 0;
      lock_end = 0; chk_pend = 0; push_pend = 0; cyc = 0;
    end else begin
      cyc++;
      m_rise = kb_key_pressed && !m_prev;
      if (q.size() > 0) m_last = q[0];
      if (!game_active) begin
        q.delete();
        m_busy = 0; lock_end = 0; chk_pend = 0; push_pend = 0;
      end else begin
        if (q.size() > 0 && hit_ready) void'(q.pop_front());
        if (push_pend && push_t == cyc) begin
          push_pend = 0;
          if (q.size() < D) q.push_back(push_code);
          else m_ov = 1;
        end
        if (chk_pend && chk_t == cyc) begin
          chk_pend = 0;
          if (chk_code < NM) begin
            push_pend = 1; push_t = cyc + 1; push_code = chk_code;
          end else if (m_inv < 255) m_inv++;
        end
        if (m_busy) begin
          if (cyc >= rel_from && !kb_key_pressed) begin
            m_busy = 0; lock_end = cyc + L + 1;
          end
        end else if (cyc >= lock_end && m_rise) begin
          m_busy = 1; rel_from = cyc + 2;
          chk_pend = 1; chk_t = cyc + 1; chk_code = int'(kb_data);
        end
      end
      m_prev = kb_key_pressed;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (!reset) begin
      check("hit_valid", hit_valid, (q.size() > 0) ? 1 : 0);
      check("hit_index", hit_index, (q.size() > 0) ? q[0] : m_last);
      check("overflow", overflow, m_ov);
      check("invalid_count", invalid_count, m_inv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] c, input int hold);
    kb_data = c;
    kb_key_pressed = 1'b1;
    repeat (hold) tick();
    kb_key_pressed = 1'b0;
    repeat (L + 4) tick();
  endtask

  initial begin
    reset = 1'b1; kb_data = '0; kb_key_pressed = 1'b0; game_active = 1'b1; hit_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_valid", hit_valid, 0);
    check("rst_index", hit_index, 0);
    check("rst_overflow", overflow, 0);
    check("rst_invalid", invalid_count, 0);

    // 1: single press, two-clock latency, exactly one entry
    kb_data = 4'd3; kb_key_pressed = 1'b1;
    tick(); check("t1_lat_n", hit_valid, 0);
    tick(); check("t1_lat_n1", hit_valid, 0);
    tick(); check("t1_lat_n2", hit_valid, 1); check("t1_index", hit_index, 3);
    repeat (17) tick();
    kb_key_pressed = 1'b0;
    repeat (L + 4) tick();
    hit_ready = 1'b1; tick(); hit_ready = 1'b0;
    check("t1_one_entry", hit_valid, 0);
    check("t1_index_hold", hit_index, 3);

    // 2: held key, early re-press ignored, late re-press accepted
    kb_data = 4'd2; kb_key_pressed = 1'b1;
    for (int i = 0; i < 100; i++) begin kb_data = 4'd2; tick(); end
    kb_key_pressed = 1'b0;
    repeat (4) tick();
    kb_key_pressed = 1'b1; repeat (2) tick(); kb_key_pressed = 1'b0;
    repeat (6) tick();
    kb_key_pressed = 1'b1; repeat (3) tick(); kb_key_pressed = 1'b0;
    repeat (L + 4) tick();
    check("t2_first", hit_index, 2);
    hit_ready = 1'b1; tick(); hit_ready = 1'b0;
    check("t2_second_valid", hit_valid, 1);
    check("t2_second", hit_index, 2);
    hit_ready = 1'b1; tick(); hit_ready = 1'b0;
    check("t2_two_entries", hit_valid, 0);

    // 3: invalid codes and saturation
    press(4'd7, 2);
    check("t3_no_hit", hit_valid, 0);
    check("t3_inv1", invalid_count, 1);
    for (int i = 0; i < 299; i++) press(4'd7, 2);
    check("t3_sat", invalid_count, 255);

    // 4: overflow then in-order drain
    for (int c = 0; c < 5; c++) press(4'(c), 2);
    check("t4_overflow", overflow, 1);
    hit_ready = 1'b1;
    check("t4_pop0", hit_index, 0);
    tick(); check("t4_pop1", hit_index, 1);
    tick(); check("t4_pop2", hit_index, 2);
    tick(); check("t4_pop3", hit_index, 3);
    tick(); check("t4_empty", hit_valid, 0); check("t4_hold", hit_index, 3);
    hit_ready = 1'b0;

    reset = 1'b1; #1;
    check("r1_overflow", overflow, 0);
    check("r1_invalid", invalid_count, 0);
    @(posedge clock); #1 reset = 1'b0;

    // 5: full FIFO, push coinciding with a pop
    for (int c = 0; c < 4; c++) press(4'(c), 2);
    check("t5_full_no_ov", overflow, 0);
    kb_data = 4'd4; kb_key_pressed = 1'b1;
    tick(); tick();
    hit_ready = 1'b1; tick(); hit_ready = 1'b0;
    kb_key_pressed = 1'b0;
    check("t5_ov", overflow, 0);
    check("t5_head", hit_index, 1);
    repeat (L + 4) tick();
    hit_ready = 1'b1;
    tick(); check("t5_e2", hit_index, 2);
    tick(); check("t5_e3", hit_index, 3);
    tick(); check("t5_e4", hit_index, 4);
    tick(); check("t5_empty", hit_valid, 0);
    hit_ready = 1'b0;

    // 6: flush keeps statistics; reset mid-lockout clears everything
    press(4'd7, 2);
    for (int c = 0; c < 5; c++) press(4'(c), 2);
    hit_ready = 1'b1; repeat (2) tick(); hit_ready = 1'b0;
    check("t6_before_flush", hit_index, 2);
    game_active = 1'b0; tick(); game_active = 1'b1;
    check("t6_flushed", hit_valid, 0);
    check("t6_ov_kept", overflow, 1);
    check("t6_inv_kept", invalid_count, 1);
    check("t6_idx_hold", hit_index, 2);
    kb_data = 4'd1; kb_key_pressed = 1'b1; repeat (3) tick();
    kb_key_pressed = 1'b0; repeat (3) tick();
    reset = 1'b1; #1;
    check("t6_rst_valid", hit_valid, 0);
    check("t6_rst_index", hit_index, 0);
    check("t6_rst_ov", overflow, 0);
    check("t6_rst_inv", invalid_count, 0);
    @(posedge clock); #1 reset = 1'b0;
    press(4'd4, 2);
    check("t6_idle_after_rst", hit_valid, 1);
    check("t6_idle_index", hit_index, 4);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
